// File: rtl/bcd_cascade_ctrl.sv
// Run/pause/stop controller for a cascade of BCD decade digits.
// An internal prescaler turns RUN cycles into count ticks. Each tick either
// increments the BCD count with a synchronous carry chain, or acts on the
// latched limit: in one-shot mode the controller halts in DONE, and in
// continuous mode the count wraps to zero with a carry pulse.
module bcd_cascade_ctrl #(
    parameter int DIGITS   = 4,
    parameter int PRESCALE = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  clear,
    input  logic                  oneshot,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic                  running,
    output logic                  done,
    output logic                  tick_out,
    output logic                  carry
);

    localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [PW-1:0]         presc_q, presc_d;
    logic [4*DIGITS-1:0]   count_q, count_d;
    logic [4*DIGITS-1:0]   limit_q, limit_d;
    logic                  oneshot_q, oneshot_d;
    logic                  tick_q, tick_d;
    logic                  carry_q, carry_d;

    // Per-digit helpers: carry chain, incremented count and limit sanitising.
    logic [DIGITS:0]       nines_below;
    logic [DIGITS-1:0]     digit_bad;
    logic [4*DIGITS-1:0]   count_inc;
    logic [4*DIGITS-1:0]   all_nines;
    logic [4*DIGITS-1:0]   limit_sane;

    assign nines_below[0] = 1'b1;

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            // A digit advances only when every lower digit is 9; a 9 rolls to 0.
            assign nines_below[gi+1] = nines_below[gi] & (count_q[4*gi +: 4] == 4'd9);
            assign count_inc[4*gi +: 4] =
                !nines_below[gi]             ? count_q[4*gi +: 4] :
                (count_q[4*gi +: 4] == 4'd9) ? 4'd0 :
                                               count_q[4*gi +: 4] + 4'd1;
            assign digit_bad[gi]         = (limit[4*gi +: 4] > 4'd9);
            assign all_nines[4*gi +: 4]  = 4'd9;
        end
    endgenerate

    // A single non-BCD limit digit makes the whole limit untrustworthy, so
    // fall back to the largest representable count.
    assign limit_sane = (|digit_bad) ? all_nines : limit;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            presc_q   <= '0;
            count_q   <= '0;
            limit_q   <= '0;
            oneshot_q <= 1'b0;
            tick_q    <= 1'b0;
            carry_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            presc_q   <= presc_d;
            count_q   <= count_d;
            limit_q   <= limit_d;
            oneshot_q <= oneshot_d;
            tick_q    <= tick_d;
            carry_q   <= carry_d;
        end
    end

    // Next-state logic; command priority is clear, then stop, then start.
    always_comb begin
        state_d   = state_q;
        presc_d   = presc_q;
        count_d   = count_q;
        limit_d   = limit_q;
        oneshot_d = oneshot_q;
        tick_d    = 1'b0;
        carry_d   = 1'b0;

        if (clear) begin
            state_d = ST_IDLE;
            presc_d = '0;
            count_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!stop && start) begin
                        state_d   = ST_RUN;
                        presc_d   = '0;
                        limit_d   = limit_sane;
                        oneshot_d = oneshot;
                    end
                end
                ST_RUN: begin
                    if (stop) begin
                        // Prescaler holds, so a tick pending on this edge
                        // fires on the first RUN edge after resume.
                        state_d = ST_PAUSED;
                    end else if (presc_q == PRESC_MAX) begin
                        presc_d = '0;
                        if (count_q == limit_q) begin
                            if (oneshot_q) begin
                                state_d = ST_DONE;
                            end else begin
                                count_d = '0;
                                tick_d  = 1'b1;
                                carry_d = 1'b1;
                            end
                        end else begin
                            count_d = count_inc;
                            tick_d  = 1'b1;
                        end
                    end else begin
                        presc_d = presc_q + 1'b1;
                    end
                end
                ST_PAUSED: begin
                    if (!stop && start) begin
                        state_d = ST_RUN;
                    end
                end
                default: begin
                    // DONE: only clear or reset leaves.
                end
            endcase
        end
    end

    assign count    = count_q;
    assign tick_out = tick_q;
    assign carry    = carry_q;
    assign running  = (state_q == ST_RUN);
    assign done     = (state_q == ST_DONE);

endmodule

// File: tb/tb_bcd_cascade_ctrl.sv
// Bench for bcd_cascade_ctrl (2 digits, prescale 3). A cycle-level reference
// model holds the count as a plain decimal integer and derives the expected
// BCD outputs from it; directed scenarios are followed by random traffic.
module tb_bcd_cascade_ctrl;

    localparam int DIGITS   = 2;
    localparam int PRESCALE = 3;
    localparam int W        = 4 * DIGITS;
    localparam int MAXV     = 99;

    localparam int S_IDLE   = 0;
    localparam int S_RUN    = 1;
    localparam int S_PAUSED = 2;
    localparam int S_DONE   = 3;

    logic          clk = 1'b0;
    logic          in_rst, in_start, in_stop, in_clear, in_oneshot;
    logic [W-1:0]  in_limit;
    logic [W-1:0]  count;
    logic          running, done, tick_out, carry;

    int checks   = 0;
    int failures = 0;

    // Reference model state.
    int m_state, m_count, m_presc, m_lim;
    bit m_os, m_tick, m_carry;

    bcd_cascade_ctrl #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
        .clk      (clk),
        .rst      (in_rst),
        .start    (in_start),
        .stop     (in_stop),
        .clear    (in_clear),
        .oneshot  (in_oneshot),
        .limit    (in_limit),
        .count    (count),
        .running  (running),
        .done     (done),
        .tick_out (tick_out),
        .carry    (carry)
    );

    always #5 clk = ~clk;

    function automatic bit bcd_valid(input logic [W-1:0] v);
        for (int i = 0; i < DIGITS; i++)
            if (v[4*i +: 4] > 4'd9) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int bcd_to_int(input logic [W-1:0] v);
        int r = 0;
        for (int i = DIGITS - 1; i >= 0; i--) r = r * 10 + int'(v[4*i +: 4]);
        return r;
    endfunction

    function automatic logic [W-1:0] int_to_bcd(input int n);
        logic [W-1:0] v = '0;
        int           x = n;
        for (int i = 0; i < DIGITS; i++) begin
            v[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return v;
    endfunction

    // Advance the model by one clock edge using the currently driven inputs.
    task automatic model_step();
        m_tick  = 1'b0;
        m_carry = 1'b0;
        if (in_rst) begin
            m_state = S_IDLE; m_count = 0; m_presc = 0; m_lim = 0; m_os = 1'b0;
        end else if (in_clear) begin
            m_state = S_IDLE; m_count = 0; m_presc = 0;
        end else begin
            case (m_state)
                S_IDLE: if (!in_stop && in_start) begin
                    m_state = S_RUN;
                    m_presc = 0;
                    m_lim   = bcd_valid(in_limit) ? bcd_to_int(in_limit) : MAXV;
                    m_os    = in_oneshot;
                end
                S_RUN: if (in_stop) begin
                    m_state = S_PAUSED;
                end else if (m_presc == PRESCALE - 1) begin
                    m_presc = 0;
                    if (m_count == m_lim) begin
                        if (m_os) m_state = S_DONE;
                        else begin m_count = 0; m_tick = 1'b1; m_carry = 1'b1; end
                    end else begin
                        m_count = m_count + 1;
                        m_tick  = 1'b1;
                    end
                end else begin
                    m_presc = m_presc + 1;
                end
                S_PAUSED: if (!in_stop && in_start) m_state = S_RUN;
                default: ;
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [W-1:0] exp_count;
        exp_count = int_to_bcd(m_count);
        checks += 5;
        assert (count === exp_count) else begin
            failures++;
            $error("FAIL count observed=%h expected=%h at %0t", count, exp_count, $time);
        end
        assert (running === (m_state == S_RUN)) else begin
            failures++;
            $error("FAIL running observed=%b expected=%b at %0t", running, (m_state == S_RUN), $time);
        end
        assert (done === (m_state == S_DONE)) else begin
            failures++;
            $error("FAIL done observed=%b expected=%b at %0t", done, (m_state == S_DONE), $time);
        end
        assert (tick_out === m_tick) else begin
            failures++;
            $error("FAIL tick_out observed=%b expected=%b at %0t", tick_out, m_tick, $time);
        end
        assert (carry === m_carry) else begin
            failures++;
            $error("FAIL carry observed=%b expected=%b at %0t", carry, m_carry, $time);
        end
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) begin
            model_step();
            @(posedge clk);
            #1;
            check_outputs();
        end
    endtask

    task automatic pulse_start();
        in_start = 1'b1; run(1); in_start = 1'b0;
    endtask

    // Run until the model is in RUN with the given prescaler (and count, if
    // cnt >= 0) just before the next edge; an exhausted budget is a failure.
    task automatic wait_for(input int cnt, input int presc, input int budget);
        bit hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            if (m_state == S_RUN && m_presc == presc && (cnt < 0 || m_count == cnt)) begin
                hit = 1'b1;
                break;
            end
            run(1);
        end
        checks++;
        assert (hit) else begin
            failures++;
            $error("FAIL wait_for observed=timeout expected=count %0d presc %0d", cnt, presc);
        end
    endtask

    task automatic set_idle_inputs();
        in_rst = 1'b0; in_start = 1'b0; in_stop = 1'b0; in_clear = 1'b0;
    endtask

    initial begin
        m_state = S_IDLE; m_count = 0; m_presc = 0; m_lim = 0;
        m_os = 1'b0; m_tick = 1'b0; m_carry = 1'b0;
        in_rst = 1'b1; in_start = 1'b1; in_stop = 1'b0; in_clear = 1'b0;
        in_oneshot = 1'b0; in_limit = 8'h12;

        // Reset held 3 cycles with start asserted, then released.
        run(3);
        in_rst = 1'b0;
        run(2);
        in_start = 1'b0;

        // Continuous mode to 0x12 and wrap.
        in_clear = 1'b1; run(1); in_clear = 1'b0;
        in_oneshot = 1'b0; in_limit = 8'h12;
        pulse_start();
        run(3 * 14 + 4);

        // One-shot mode: halt in DONE, ignore start/stop, leave on clear.
        in_clear = 1'b1; run(1); in_clear = 1'b0;
        in_oneshot = 1'b1;
        pulse_start();
        run(3 * 13 + 3);
        for (int k = 0; k < 5; k++) begin
            pulse_start();
            in_stop = 1'b1; run(1); in_stop = 1'b0;
            run(2);
        end
        in_clear = 1'b1; run(1); in_clear = 1'b0;
        run(2);

        // Pause mid-interval at count 05, prescaler 1.
        in_oneshot = 1'b0; in_limit = 8'h12;
        pulse_start();
        wait_for(5, 1, 100);
        in_stop = 1'b1; run(10);
        in_stop = 1'b0; pulse_start();
        run(6);

        // Stop on the tick edge, then resume.
        wait_for(-1, PRESCALE - 1, 20);
        in_stop = 1'b1; run(3);
        in_stop = 1'b0; pulse_start();
        run(4);

        // Start and stop together in PAUSED: stop wins.
        in_stop = 1'b1; run(1);
        in_start = 1'b1; run(3);
        in_stop = 1'b0; run(1); in_start = 1'b0;
        run(2);

        // Clear with start on the tick edge.
        wait_for(-1, PRESCALE - 1, 20);
        in_clear = 1'b1; in_start = 1'b1; run(1);
        in_clear = 1'b0; in_start = 1'b0;
        run(3);

        // Invalid limit falls back to 99; limit changes while running ignored.
        in_limit = 8'h1A; in_oneshot = 1'b0;
        pulse_start();
        for (int k = 0; k < 320; k++) begin
            in_limit = 8'($urandom);
            run(1);
        end
        in_clear = 1'b1; run(1); in_clear = 1'b0;

        // Random traffic against the model.
        for (int k = 0; k < 1500; k++) begin
            set_idle_inputs();
            in_rst     = ($urandom_range(0, 199) == 0);
            in_clear   = ($urandom_range(0, 59) == 0);
            in_stop    = ($urandom_range(0, 9) == 0);
            in_start   = ($urandom_range(0, 3) == 0);
            in_oneshot = 1'($urandom);
            in_limit   = ($urandom_range(0, 4) == 0) ? 8'($urandom)
                                                     : int_to_bcd($urandom_range(0, 30));
            run(1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
